// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M execute unit (shift-add multiply, restoring divide).
// One bit per cycle on operand magnitudes; signs are applied in FIX.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            sel_i,
    input  logic [1:0]      op_mul_i,
    input  logic [1:0]      op_div_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_q, sel_d, neg_q, neg_d, rneg_q, rneg_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;

    logic              rs1_sgn, rs2_sgn, neg_a, neg_b, div_zero, div_ovf, div_ge;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res, quo_fix, rem_fix, fix_res;
    logic [XLEN:0]     mul_sum, div_sh;
    logic [2*XLEN-1:0] prod_fix;

    assign rs1_sgn  = sel_i ? ~op_div_i[0] : (op_mul_i != 2'b11);
    assign rs2_sgn  = sel_i ? ~op_div_i[0] : ~op_mul_i[1];
    assign neg_a    = rs1_sgn & rs1_i[XLEN-1];
    assign neg_b    = rs2_sgn & rs2_i[XLEN-1];
    assign a_mag    = neg_a ? -rs1_i : rs1_i;
    assign b_mag    = neg_b ? -rs2_i : rs2_i;
    assign div_zero = rs2_i == '0;
    assign div_ovf  = ~op_div_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
    assign fast_res = div_zero ? (op_div_i[1] ? rs1_i : '1)
                               : (op_div_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // acc holds {partial product high, remaining multiplier} for multiply
    // and {0, dividend shifting into quotient} for divide
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_q[0]}} & {1'b0, opnd_q});
    assign div_sh   = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    assign div_ge   = rem_q[XLEN] | (div_sh >= {1'b0, opnd_q});
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    assign fix_res  = sel_q ? (op_q[1] ? rem_fix : quo_fix)
                            : (op_q == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start_i && !flush_i) begin
                sel_d   = sel_i;
                op_d    = sel_i ? op_div_i : op_mul_i;
                neg_d   = neg_a ^ neg_b;
                rneg_d  = neg_a;
                opnd_d  = sel_i ? b_mag : a_mag;
                acc_d   = {{XLEN{1'b0}}, sel_i ? a_mag : b_mag};
                rem_d   = '0;
                cnt_d   = '0;
                state_d = CALC;
                if (sel_i && (div_zero || div_ovf)) begin
                    state_d  = DONE;
                    result_d = fast_res;
                end
            end
            CALC: if (flush_i) state_d = IDLE;
            else begin
                if (sel_q) begin
                    rem_d = div_ge ? div_sh - {1'b0, opnd_q} : div_sh;
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
                end else
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == '1) ? FIX : CALC;
            end
            FIX: if (flush_i) state_d = IDLE;
            else begin
                state_d  = DONE;
                result_d = fix_res;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == CALC) || (state_q == FIX);
    assign done_o   = state_q == DONE;
    assign result_o = result_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative M-extension execute unit. Responds to the decoder's muldiv_start / muldiv_sel / op_mul / op_div issue signals in EX.
- Computes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on rs1/rs2 operands.
- Stalls the pipeline through busy_o. Returns a registered result with a one-cycle done_o pulse, which the EX output mux selects on code 2'b10.

Parameters:
XLEN, 32, operand and result width
CNT_W, 5, iteration counter width; log2(XLEN)

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  muldiv_start from decode; level, held while instruction sits in EX
sel_i  in  1  0 = multiply, 1 = divide (funct3[2])
op_mul_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
op_div_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_i  in  XLEN  operand A (multiplicand / dividend)
rs2_i  in  XLEN  operand B (multiplier / divisor)
flush_i  in  1  synchronous abort (exception, mret, branch flush)
busy_o  out  1  operation in progress; core stalls EX
done_o  out  1  one-cycle pulse, result_o valid
result_o  out  XLEN  registered result, held until next completion

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, busy_o=0, done_o=0, result_o=0, counter=0, internal registers 0. Deassertion takes effect on the next clk_i edge.
- States: IDLE, CALC, FIX, DONE.
- Acceptance:
  - An operation is accepted only in IDLE with start_i=1 and flush_i=0.
  - start_i in CALC, FIX or DONE is ignored; there is no re-trigger from the held level.
  - On acceptance, the unit latches sel/op and operand magnitudes plus sign flags.
  - Signed treatment: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU/DIVU/REMU treat both as unsigned.
- Timing, with cycle 0 = the cycle start_i is sampled in IDLE:
  - Normal path: cycles 1-32 CALC (one iteration per cycle, counter 0..31); cycle 33 FIX; cycle 34 DONE with done_o=1. Return to IDLE at cycle 35.
  - busy_o=1 in CALC and FIX, and 0 in IDLE and DONE.
- Multiply:
  - Radix-2 shift-add on 32-bit magnitudes into a 64-bit product.
  - FIX negates the product when the operand signs differ, considering signed operands only.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring division on magnitudes.
  - FIX sets quotient sign = sign(rs1) XOR sign(rs2), and remainder sign = sign(rs1), for DIV/REM only.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Fast path (divide only), detected on acceptance: cycle 0 -> DONE in cycle 1, busy_o never asserted.
  - Divisor = 0: quotient = 0xFFFFFFFF for DIV and DIVU; remainder = rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Multiply always takes the full 34-cycle latency; there is no zero-operand early-out.
- flush_i:
  - In CALC or FIX: next state IDLE, busy_o drops next cycle, no done_o, result_o unchanged.
  - In IDLE: blocks acceptance.
  - In DONE: done_o still pulses this cycle and the state returns to IDLE.
- result_o updates only on entry to DONE and is held otherwise.
- done_o is never asserted for two consecutive cycles.
- Arithmetic widths: the partial remainder register is XLEN+1 bits. The product accumulator is 2*XLEN bits. Negation is two's complement at full width. No X-propagation from unused op fields.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at cycle 0 -> busy_o high cycles 1-33, done_o only at cycle 34, result_o=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MUL low of the same operands -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each has done_o at cycle 34.
- Divide by zero: DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All fast-path cases: done_o at cycle 1, busy_o never high.
- start_i held high for 40 cycles with one DIV -> exactly one done_o pulse at cycle 34, then re-acceptance at cycle 35, second done_o at cycle 69.
- flush_i at cycle 10 of a MUL -> busy_o low at cycle 11, no done_o, result_o keeps the prior value. Separately, rst_ni low at cycle 20 -> outputs immediately 0, state IDLE, and the next operation completes correctly.
